// File: rtl/tile_fetch_pkg.sv
// +----------------------------------------------------------------------------+
// | Module : tile_fetch_pkg                                                    |
// | Brief  : Shared constants for the tile-pixel fetch engine: FSM state       |
// |          encodings, default error/key colours and a counter-width helper.  |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package tile_fetch_pkg;

    // FSM state encodings (2-bit)
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_req  = 2'd1;
    localparam logic [1:0] c_st_wait = 2'd2;
    localparam logic [1:0] c_st_resp = 2'd3;

    // Default colours
    localparam logic [23:0] c_error_rgb_default = 24'hFF00FF;
    localparam logic [23:0] c_key_rgb_default   = 24'h000000;

    // Bits needed to hold the values 0 .. value-1 (at least 1 bit)
    function automatic int tf_clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tile_addr_gen.sv
// +----------------------------------------------------------------------------+
// | Module : tile_addr_gen                                                     |
// | Brief  : Combinational mirror and tile-pixel to ROM word-address mapping.  |
// |          Shared with the tilemap walker.                                   |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tile_addr_gen #(
    parameter int TILE_W_LOG2 = 2,
    parameter int TILE_H_LOG2 = 2,
    parameter int TILE_NO_W   = 4,
    parameter int ROM_ADDR_W  = 9,
    parameter int BASE_ADDR   = 0
) (
    input  logic [TILE_NO_W-1:0]   i_tile_no,
    input  logic [TILE_W_LOG2-1:0] i_tile_x,
    input  logic [TILE_H_LOG2-1:0] i_tile_y,
    input  logic [1:0]             i_mirror,
    output logic [ROM_ADDR_W-1:0]  o_address
);

    localparam int                    c_idx_w = TILE_NO_W + TILE_H_LOG2 + TILE_W_LOG2;
    localparam logic [ROM_ADDR_W-1:0] c_base  = ROM_ADDR_W'(BASE_ADDR);

    logic [TILE_W_LOG2-1:0] w_xm;
    logic [TILE_H_LOG2-1:0] w_ym;
    logic [c_idx_w-1:0]     w_idx;

    // Flip inside the tile (2^N-1-v is the bitwise complement), then offset by the base
    always_comb begin
        w_xm      = i_mirror[0] ? ~i_tile_x : i_tile_x;
        w_ym      = i_mirror[1] ? ~i_tile_y : i_tile_y;
        w_idx     = {i_tile_no, w_ym, w_xm};
        o_address = c_base + ROM_ADDR_W'(w_idx);
    end

endmodule

`default_nettype wire

// File: rtl/tile_fetch.sv
// +----------------------------------------------------------------------------+
// | Module : tile_fetch                                                        |
// | Brief  : Tile-pixel fetch engine. Maps a (tile, x, y, mirror) request to a |
// |          ROM word address, runs a single-outstanding ROM read with timeout |
// |          and returns the 24-bit RGB pixel.                                 |
// |          Optional feature macro: TILE_FETCH_TRANSPARENCY_EN                |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tile_fetch
    import tile_fetch_pkg::*;
#(
    parameter int          TILE_W_LOG2    = 2,
    parameter int          TILE_H_LOG2    = 2,
    parameter int          TILE_NO_W      = 4,
    parameter int          ROM_ADDR_W     = 9,
    parameter int          BASE_ADDR      = 0,
    parameter int          TIMEOUT_CYCLES = 15,
    parameter logic [23:0] ERROR_RGB      = c_error_rgb_default,
    parameter logic [23:0] KEY_RGB        = c_key_rgb_default
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_read,
    input  logic [TILE_NO_W-1:0]   i_tile_no,
    input  logic [TILE_W_LOG2-1:0] i_tile_x,
    input  logic [TILE_H_LOG2-1:0] i_tile_y,
    input  logic [1:0]             i_mirror,
    output logic                   o_ready,
    output logic [23:0]            o_rgb_data,
    output logic                   o_valid,
    output logic                   o_error,
    output logic                   o_transparent,
    output logic [ROM_ADDR_W-1:0]  o_rom_address,
    output logic                   o_rom_read,
    input  logic [23:0]            i_rom_data,
    input  logic                   i_rom_valid
);

    localparam int                 c_cnt_w    = tf_clog2(TIMEOUT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYCLES - 1);

`ifdef TILE_FETCH_TRANSPARENCY_EN
    localparam bit c_transp_en = 1'b1;
`else
    // Without the feature the transparency register is constant zero
    localparam bit c_transp_en = 1'b0;
`endif

    logic [1:0]            r_state;
    logic [1:0]            w_state_next;
    logic [c_cnt_w-1:0]    r_cnt;
    logic [ROM_ADDR_W-1:0] r_rom_address;
    logic [ROM_ADDR_W-1:0] w_addr;
    logic [23:0]           r_rgb;
    logic                  r_err;
    logic                  r_transparent;
    logic                  w_cnt_last;

    tile_addr_gen #(
        .TILE_W_LOG2 (TILE_W_LOG2),
        .TILE_H_LOG2 (TILE_H_LOG2),
        .TILE_NO_W   (TILE_NO_W),
        .ROM_ADDR_W  (ROM_ADDR_W),
        .BASE_ADDR   (BASE_ADDR)
    ) u_addr_gen (
        .i_tile_no (i_tile_no),
        .i_tile_x  (i_tile_x),
        .i_tile_y  (i_tile_y),
        .i_mirror  (i_mirror),
        .o_address (w_addr)
    );

    assign w_cnt_last = (r_cnt == c_cnt_last);

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic; ROM data beats a coincident timeout
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_st_idle: if (i_read) w_state_next = c_st_req;
            c_st_req:  w_state_next = c_st_wait;
            c_st_wait: if (i_rom_valid || w_cnt_last) w_state_next = c_st_resp;
            c_st_resp: w_state_next = c_st_idle;
            default:   w_state_next = c_st_idle;
        endcase
    end

    // Moore outputs decoded from the current state
    always_comb begin
        o_ready    = (r_state == c_st_idle);
        o_rom_read = (r_state == c_st_req);
        o_valid    = (r_state == c_st_resp);
        o_error    = (r_state == c_st_resp) && r_err;
    end

    // Request latch, timeout counter and response registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rom_address <= '0;
            r_cnt         <= '0;
            r_rgb         <= '0;
            r_err         <= 1'b0;
            r_transparent <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (i_read) begin
                        r_rom_address <= w_addr;
                    end
                end
                c_st_req: begin
                    r_cnt <= '0;
                end
                c_st_wait: begin
                    if (i_rom_valid) begin
                        r_rgb         <= i_rom_data;
                        r_err         <= 1'b0;
                        r_transparent <= c_transp_en && (i_rom_data == KEY_RGB);
                    end else if (w_cnt_last) begin
                        r_rgb         <= ERROR_RGB;
                        r_err         <= 1'b1;
                        r_transparent <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_rgb_data    = r_rgb;
    assign o_rom_address = r_rom_address;
    assign o_transparent = r_transparent;

endmodule

`default_nettype wire

// File: tb/tb_tile_fetch.sv
// +----------------------------------------------------------------------------+
// | Module : tb_tile_fetch                                                     |
// | Brief  : Self-checking bench for tile_fetch: table vectors, randomized     |
// |          requests against an arithmetic reference model, and hand-written  |
// |          multi-cycle sequences. Honours TILE_FETCH_TRANSPARENCY_EN.        |
// | Rev    : 1.0  initial release                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_tile_fetch;

    localparam int          TIMEOUT   = 15;
    localparam int          BASE      = 0;
    localparam logic [23:0] ERR_RGB   = 24'hFF00FF;
    localparam logic [23:0] KEY       = 24'h000000;
`ifdef TILE_FETCH_TRANSPARENCY_EN
    localparam bit          TRANSP_EN = 1'b1;
`else
    localparam bit          TRANSP_EN = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_read = 1'b0;
    logic [3:0]  i_tile_no = '0;
    logic [1:0]  i_tile_x = '0;
    logic [1:0]  i_tile_y = '0;
    logic [1:0]  i_mirror = '0;
    logic        o_ready;
    logic [23:0] o_rgb_data;
    logic        o_valid;
    logic        o_error;
    logic        o_transparent;
    logic [8:0]  o_rom_address;
    logic        o_rom_read;
    logic [23:0] i_rom_data = '0;
    logic        i_rom_valid = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    tile_fetch #(
        .TILE_W_LOG2    (2),
        .TILE_H_LOG2    (2),
        .TILE_NO_W      (4),
        .ROM_ADDR_W     (9),
        .BASE_ADDR      (BASE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .ERROR_RGB      (ERR_RGB),
        .KEY_RGB        (KEY)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_read        (i_read),
        .i_tile_no     (i_tile_no),
        .i_tile_x      (i_tile_x),
        .i_tile_y      (i_tile_y),
        .i_mirror      (i_mirror),
        .o_ready       (o_ready),
        .o_rgb_data    (o_rgb_data),
        .o_valid       (o_valid),
        .o_error       (o_error),
        .o_transparent (o_transparent),
        .o_rom_address (o_rom_address),
        .o_rom_read    (o_rom_read),
        .i_rom_data    (i_rom_data),
        .i_rom_valid   (i_rom_valid)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference address: mirrored pixel position inside a 4x4 tile, 16 words per tile
    function automatic logic [8:0] model_addr(input int tile, input int x, input int y, input int mir);
        int xm, ym, a;
        xm = mir[0] ? (3 - x) : x;
        ym = mir[1] ? (3 - y) : y;
        a  = (BASE + tile * 16 + ym * 4 + xm) % 512;
        return a[8:0];
    endfunction

    // One full transaction. delay = WAIT cycle (0-based) in which the ROM answers; <0 = never
    task automatic txn(input logic [3:0] tile, input logic [1:0] x, input logic [1:0] y,
                       input logic [1:0] mir, input int delay, input logic [23:0] data,
                       input logic [8:0] exp_addr);
        logic        exp_err, exp_tr, held_ok, seen;
        logic [23:0] exp_rgb;
        int          exp_cyc, got_cyc;
        exp_err = (delay < 0) || (delay >= TIMEOUT);
        exp_rgb = exp_err ? ERR_RGB : data;
        exp_cyc = exp_err ? TIMEOUT : delay + 1;
        exp_tr  = TRANSP_EN && !exp_err && (data == KEY);
        held_ok = 1'b1;
        seen    = 1'b0;
        got_cyc = -1;

        @(negedge i_clk);
        check("ready_idle", {31'd0, o_ready}, 1);
        i_read = 1'b1; i_tile_no = tile; i_tile_x = x; i_tile_y = y; i_mirror = mir;
        i_rom_valid = 1'b0;
        @(negedge i_clk);
        i_read = 1'b0;
        i_tile_no = 4'($urandom); i_tile_x = 2'($urandom); i_tile_y = 2'($urandom); i_mirror = 2'($urandom);
        check("req_rom_read", {30'd0, o_rom_read, o_ready}, 2);
        check("rom_address", {23'd0, o_rom_address}, {23'd0, exp_addr});
        for (int c = 0; c < 40; c++) begin
            @(negedge i_clk);
            if (o_valid) begin
                seen    = 1'b1;
                got_cyc = c;
                break;
            end
            if (o_rom_read || o_ready || o_rom_address != exp_addr) held_ok = 1'b0;
            i_rom_valid = (c == delay);
            i_rom_data  = (c == delay) ? data : 24'($urandom);
        end
        i_rom_valid = 1'b0;
        check("wait_addr_held", {31'd0, held_ok}, 1);
        if (!seen) begin
            check("resp_seen", {31'd0, o_valid}, 1);
        end else begin
            check("latency", got_cyc, exp_cyc);
            check("rgb", {8'd0, o_rgb_data}, {8'd0, exp_rgb});
            check("error", {31'd0, o_error}, {31'd0, exp_err});
            check("transparent", {31'd0, o_transparent}, {31'd0, exp_tr});
        end
        @(negedge i_clk);
        check("pulse_end", {29'd0, o_valid, o_error, o_ready}, 3'b001);
        check("rgb_held", {8'd0, o_rgb_data}, {8'd0, exp_rgb});
        check("transp_held", {31'd0, o_transparent}, {31'd0, exp_tr});
    endtask

    typedef struct {
        logic [3:0]  tile;
        logic [1:0]  x;
        logic [1:0]  y;
        logic [1:0]  mir;
        int          delay;
        logic [23:0] data;
        logic [8:0]  exp_addr;
    } vec_t;

    vec_t tbl[10];

    initial begin
        int n_rd, n_v, n_busy;
        logic rd_prev;

        tbl[0] = '{4'd3,  2'd1, 2'd2, 2'd0, 0,  24'h000039, 9'h039};
        tbl[1] = '{4'd3,  2'd1, 2'd2, 2'd3, 0,  24'h000036, 9'h036};
        tbl[2] = '{4'd3,  2'd1, 2'd2, 2'd1, 0,  24'h00003A, 9'h03A};
        tbl[3] = '{4'd3,  2'd1, 2'd2, 2'd2, 0,  24'h000035, 9'h035};
        tbl[4] = '{4'd3,  2'd1, 2'd2, 2'd0, -1, 24'h000000, 9'h039};
        tbl[5] = '{4'd15, 2'd3, 2'd3, 2'd0, 2,  24'hFFFFFF, 9'h0FF};
        tbl[6] = '{4'd0,  2'd0, 2'd0, 2'd3, 5,  24'h00000F, 9'h00F};
        tbl[7] = '{4'd7,  2'd2, 2'd3, 2'd1, 14, 24'h0A0B0C, 9'h07D};
        tbl[8] = '{4'd5,  2'd0, 2'd0, 2'd0, 0,  24'h000000, 9'h050};
        tbl[9] = '{4'd5,  2'd0, 2'd0, 2'd0, 1,  24'h000001, 9'h050};

        // Reset state
        repeat (2) @(negedge i_clk);
        check("rst_outputs", {28'd0, o_ready, o_valid, o_error, o_rom_read}, 4'b1000);
        check("rst_rgb", {8'd0, o_rgb_data}, 0);
        check("rst_addr", {23'd0, o_rom_address}, 0);
        check("rst_transp", {31'd0, o_transparent}, 0);
        i_rst_n = 1'b1;

        // Table vectors
        for (int i = 0; i < 10; i++) begin
            txn(tbl[i].tile, tbl[i].x, tbl[i].y, tbl[i].mir, tbl[i].delay, tbl[i].data, tbl[i].exp_addr);
        end

        // Late ROM answer after a timeout, and ROM valid while idle, are ignored
        txn(4'd9, 2'd2, 2'd1, 2'd0, -1, 24'h0, model_addr(9, 2, 1, 0));
        @(negedge i_clk);
        i_rom_valid = 1'b1; i_rom_data = 24'h123456;
        @(negedge i_clk);
        i_rom_valid = 1'b0;
        check("late_no_valid", {31'd0, o_valid}, 0);
        @(negedge i_clk);
        check("late_rgb_kept", {8'd0, o_rgb_data}, {8'd0, ERR_RGB});

        // Randomized requests against the reference model
        for (int i = 0; i < 30; i++) begin
            logic [3:0]  t;
            logic [1:0]  x, y, m;
            logic [23:0] d;
            int          dl;
            t  = 4'($urandom); x = 2'($urandom); y = 2'($urandom); m = 2'($urandom);
            d  = ($urandom_range(0, 3) == 0) ? 24'h0 : 24'($urandom);
            dl = $urandom_range(0, 20);
            txn(t, x, y, m, dl, d, model_addr(int'(t), int'(x), int'(y), int'(m)));
        end

        // i_read held over 3 cycles: one ROM read, one response, busy REQ..RESP
        n_rd = 0; n_v = 0; n_busy = 0; rd_prev = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge i_clk);
            if (o_rom_read) n_rd++;
            if (o_valid)    n_v++;
            if (!o_ready)   n_busy++;
            i_read      = (c < 3);
            i_tile_no   = 4'd2; i_tile_x = 2'd3; i_tile_y = 2'd0; i_mirror = 2'd0;
            i_rom_valid = rd_prev;
            i_rom_data  = 24'hABCDEF;
            rd_prev     = o_rom_read;
        end
        i_rom_valid = 1'b0;
        check("hold_rom_reads", n_rd, 1);
        check("hold_valids", n_v, 1);
        check("hold_busy_cycles", n_busy, 3);
        check("hold_rgb", {8'd0, o_rgb_data}, 32'h00ABCDEF);

        // Reset during WAIT aborts the transaction
        @(negedge i_clk);
        i_read = 1'b1; i_tile_no = 4'd3; i_tile_x = 2'd1; i_tile_y = 2'd2; i_mirror = 2'd0;
        @(negedge i_clk);
        i_read = 1'b0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        check("abort_outputs", {28'd0, o_ready, o_valid, o_error, o_rom_read}, 4'b1000);
        check("abort_rgb", {8'd0, o_rgb_data}, 0);
        check("abort_addr", {23'd0, o_rom_address}, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        i_rom_valid = 1'b1; i_rom_data = 24'h5A5A5A;
        @(negedge i_clk);
        i_rom_valid = 1'b0;
        n_v = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge i_clk);
            if (o_valid) n_v++;
        end
        check("abort_no_valid", n_v, 0);
        check("abort_rgb_kept", {8'd0, o_rgb_data}, 0);

        // Normal operation after the abort
        txn(4'd3, 2'd1, 2'd2, 2'd0, 0, 24'h000039, 9'h039);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
